chan_dump: RTL and testbench
============================

Name: chan_dump

Overview:
- Read-side counterpart of the channel capture writer.
- Once a capture has completed, it reads every entry of one channel's sample RAM queue in chronological order, oldest sample first. The start point wraps at the capture write pointer.
- Each sample byte goes to the UART transmitter over a trmt/tx_done handshake.
- When the last byte is acknowledged, it clears the capture-done flag so a new capture can be run.

Parameters:
- ENTRIES, 384, number of RAM queue entries (12288 on DE0); need not be a power of 2.
- LOG2, 9, address width; 2**LOG2 >= ENTRIES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- capture_done  input  1  capture finished; RAM contents valid
- waddr  input  LOG2  capture write pointer = address of oldest sample
- dump_start  input  1  single-cycle request to dump
- dump_abort  input  1  single-cycle abort of a dump in progress
- raddr  output  LOG2  registered RAM read address
- rdata  input  8  RAM read data, valid 1 cycle after raddr is sampled (synchronous RAM)
- tx_data  output  8  byte to UART transmitter
- trmt  output  1  single-cycle transmit strobe
- tx_done  input  1  transmitter finished current byte
- busy  output  1  dump in progress
- dump_rej  output  1  single-cycle pulse when dump_start is refused
- dump_done  output  1  single-cycle pulse when all ENTRIES bytes are acknowledged
- clr_cap_done  output  1  single-cycle pulse to the capture block, coincident with dump_done

Behaviour:
- Reset: all of the following are forced on rising clk while rst_n=0, including mid-dump; any byte in flight is abandoned.
  - state=IDLE.
  - raddr=0, tx_data=0, cnt=0.
  - trmt, busy, dump_rej, dump_done and clr_cap_done all 0.
- Internal counter cnt is LOG2 bits and runs 0..ENTRIES-1.
- Next-address rule: nxt = raddr+1 computed at LOG2+1 bits; if nxt == ENTRIES then nxt = 0. No power-of-2 wrap is ever relied on.
- IDLE:
  - If dump_start && capture_done: raddr<=waddr, cnt<=0, busy<=1, go to RD_WAIT.
  - If dump_start && !capture_done: dump_rej=1 for that cycle; stay in IDLE.
- RD_WAIT: one cycle while the RAM samples raddr; go to LOAD.
- LOAD: tx_data<=rdata, trmt<=1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX:
  - Hold tx_data stable; trmt=0.
  - On tx_done with cnt == ENTRIES-1: go to DONE.
  - On tx_done otherwise: cnt<=cnt+1, raddr<=nxt, go to RD_WAIT.
  - tx_done in any other state is ignored.
- DONE: dump_done=1 and clr_cap_done=1 for one cycle, busy<=0, go to IDLE.
- Latency: dump_start at cycle 0 gives trmt high in cycle 3. Each subsequent byte has trmt 3 cycles after the tx_done that acknowledged the previous byte.
- dump_abort in any non-IDLE state:
  - Next state is IDLE and busy<=0.
  - No dump_done, no clr_cap_done; capture data is preserved for a re-dump.
  - Abort takes priority over tx_done in the same cycle.
  - dump_abort in IDLE is ignored.
- dump_start while busy is ignored; dump_rej is not pulsed.
- waddr is sampled only at start; changes during a dump are ignored.
- Byte count per dump is exactly ENTRIES. Address sequence is waddr, waddr+1, …, ENTRIES-1, 0, …, waddr-1.

Decomposition:
- Shared package la_pkg holds:
  - the state enum dump_state_t {IDLE, RD_WAIT, LOAD, WAIT_TX, DONE};
  - ENTRIES/LOG2 defaults.
- Natural sub-module: dump_addr_gen, containing the raddr register, cnt, the modulo-ENTRIES increment and the last-entry flag. The FSM and the tx_data/strobe registers stay in chan_dump.

Test Plan:
- Bench uses ENTRIES=8, LOG2=3, a RAM model with rdata=8'hA0+addr, and a UART model that raises tx_done 5 cycles after trmt.
1. capture_done=1, waddr=3, dump_start -> bytes A3,A4,A5,A6,A7,A0,A1,A2; one dump_done and one clr_cap_done pulse after A2 is acknowledged; busy low afterwards.
2. waddr=0 -> bytes A0..A7 in order, no wrap glitch; dump_start at cycle 0 -> trmt at cycle 3; exactly 8 trmt pulses.
3. capture_done=0, dump_start -> dump_rej pulse, busy stays 0, no trmt.
4. dump_abort pulsed after the 3rd byte -> IDLE next cycle, busy=0, no dump_done; a new dump_start restarts from waddr with byte A3 (waddr=3).
5. rst_n=0 for one cycle during WAIT_TX -> all outputs 0 on the following edge; tx_done arriving afterwards produces no trmt.
6. dump_start held/pulsed while busy, and tx_done asserted in the same cycle as dump_abort -> sequence unaffected by the start; abort wins.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and default sizing for the logic-analyser capture/dump blocks.
// The dump FSM state encoding lives here so checkers and siblings can reuse it.
package la_pkg;

   localparam int ENTRIES_DEF = 384;
   localparam int LOG2_DEF    = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      LOAD    = 3'd2,
      WAIT_TX = 3'd3,
      DONE    = 3'd4
   } dump_state_t;

endpackage

// File: rtl/chan_dump_if.sv
// Control, RAM-read and UART-transmit signals of the channel dump block.
// The master side is the dump engine; the slave side is its environment.
interface chan_dump_if
   import la_pkg::*;
#(
   parameter int LOG2 = LOG2_DEF
);

   logic            capture_done;
   logic [LOG2-1:0] waddr;
   logic            dump_start;
   logic            dump_abort;
   logic [LOG2-1:0] raddr;
   logic [7:0]      rdata;
   logic [7:0]      tx_data;
   logic            trmt;
   logic            tx_done;
   logic            busy;
   logic            dump_rej;
   logic            dump_done;
   logic            clr_cap_done;

   modport master (
      input  capture_done, waddr, dump_start, dump_abort, rdata, tx_done,
      output raddr, tx_data, trmt, busy, dump_rej, dump_done, clr_cap_done
   );

   modport slave (
      output capture_done, waddr, dump_start, dump_abort, rdata, tx_done,
      input  raddr, tx_data, trmt, busy, dump_rej, dump_done, clr_cap_done
   );

endinterface

// File: rtl/dump_addr_gen.sv
// Read-address walker for the sample queue: starts at the capture write pointer
// and steps modulo ENTRIES, counting bytes so the FSM knows the last entry.
module dump_addr_gen
   import la_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int LOG2    = LOG2_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            step,
   input  logic [LOG2-1:0] waddr,
   output logic [LOG2-1:0] raddr,
   output logic            last
);

   localparam logic [LOG2:0]   ENTRIES_W = (LOG2+1)'(ENTRIES);
   localparam logic [LOG2-1:0] LAST_CNT  = LOG2'(ENTRIES - 1);
   localparam logic [LOG2-1:0] ONE       = LOG2'(1);

   logic [LOG2-1:0] raddr_r;
   logic [LOG2-1:0] cnt_r;
   logic [LOG2:0]   nxt_wide_s;
   logic [LOG2-1:0] nxt_s;

   // Modulo-ENTRIES increment, computed one bit wider so non-power-of-2 depths wrap exactly.
   always_comb begin
      nxt_wide_s = {1'b0, raddr_r} + {1'b0, ONE};
      if (nxt_wide_s == ENTRIES_W) begin
         nxt_s = {LOG2{1'b0}};
      end else begin
         nxt_s = nxt_wide_s[LOG2-1:0];
      end
   end

   // Address and byte-count registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         raddr_r <= {LOG2{1'b0}};
         cnt_r   <= {LOG2{1'b0}};
      end else if (load) begin
         raddr_r <= waddr;
         cnt_r   <= {LOG2{1'b0}};
      end else if (step) begin
         raddr_r <= nxt_s;
         cnt_r   <= cnt_r + ONE;
      end else begin
         raddr_r <= raddr_r;
         cnt_r   <= cnt_r;
      end
   end

   assign raddr = raddr_r;
   assign last  = (cnt_r == LAST_CNT);

endmodule

// File: rtl/chan_dump.sv
// Streams one channel's captured samples, oldest first, to the UART transmitter
// and releases the capture-done flag once every byte has been acknowledged.
module chan_dump
   import la_pkg::*;
#(
   parameter int ENTRIES = ENTRIES_DEF,
   parameter int LOG2    = LOG2_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   chan_dump_if.master bus
);

   dump_state_t     state_r;
   dump_state_t     state_nxt_s;
   logic [7:0]      tx_data_r;
   logic [7:0]      tx_data_nxt_s;
   logic            trmt_r;
   logic            trmt_nxt_s;
   logic            busy_r;
   logic            busy_nxt_s;
   logic            rej_r;
   logic            rej_nxt_s;
   logic            done_r;
   logic            done_nxt_s;
   logic            load_s;
   logic            step_s;
   logic            last_s;
   logic [LOG2-1:0] raddr_s;

   dump_addr_gen #(
      .ENTRIES (ENTRIES),
      .LOG2    (LOG2)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_s),
      .step  (step_s),
      .waddr (bus.waddr),
      .raddr (raddr_s),
      .last  (last_s)
   );

   // Next-state and next-output logic; abort outranks tx_done in every busy state.
   always_comb begin
      state_nxt_s   = state_r;
      tx_data_nxt_s = tx_data_r;
      trmt_nxt_s    = 1'b0;
      busy_nxt_s    = busy_r;
      rej_nxt_s     = 1'b0;
      done_nxt_s    = 1'b0;
      load_s        = 1'b0;
      step_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.dump_start && bus.capture_done) begin
               load_s      = 1'b1;
               busy_nxt_s  = 1'b1;
               state_nxt_s = RD_WAIT;
            end else if (bus.dump_start) begin
               rej_nxt_s   = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RD_WAIT: begin
            if (bus.dump_abort) begin
               busy_nxt_s  = 1'b0;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = LOAD;
            end
         end
         LOAD: begin
            if (bus.dump_abort) begin
               busy_nxt_s  = 1'b0;
               state_nxt_s = IDLE;
            end else begin
               tx_data_nxt_s = bus.rdata;
               trmt_nxt_s    = 1'b1;
               state_nxt_s   = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (bus.dump_abort) begin
               busy_nxt_s  = 1'b0;
               state_nxt_s = IDLE;
            end else if (bus.tx_done && last_s) begin
               done_nxt_s  = 1'b1;
               state_nxt_s = DONE;
            end else if (bus.tx_done) begin
               step_s      = 1'b1;
               state_nxt_s = RD_WAIT;
            end else begin
               state_nxt_s = WAIT_TX;
            end
         end
         DONE: begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
         end
         default: begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and output registers; the done pulse is registered on entry to DONE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         tx_data_r <= 8'h00;
         trmt_r    <= 1'b0;
         busy_r    <= 1'b0;
         rej_r     <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         tx_data_r <= tx_data_nxt_s;
         trmt_r    <= trmt_nxt_s;
         busy_r    <= busy_nxt_s;
         rej_r     <= rej_nxt_s;
         done_r    <= done_nxt_s;
      end
   end

   assign bus.raddr        = raddr_s;
   assign bus.tx_data      = tx_data_r;
   assign bus.trmt         = trmt_r;
   assign bus.busy         = busy_r;
   assign bus.dump_rej     = rej_r;
   assign bus.dump_done    = done_r;
   assign bus.clr_cap_done = done_r;

endmodule

// File: tb/tb_chan_dump.sv
// Scoreboard bench for chan_dump: expected bytes are queued by the stimulus,
// a negedge monitor pops and compares each byte the DUT strobes out.
module tb_chan_dump;

   localparam int ENT = 8;
   localparam int LG  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   chan_dump_if #(.LOG2(LG)) bus ();

   chan_dump #(.ENTRIES(ENT), .LOG2(LG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Synchronous RAM model: contents are A0 + address.
   always @(posedge clk) bus.rdata <= 8'hA0 + {5'd0, bus.raddr};

   // UART model: tx_done five cycles after each observed trmt.
   logic tx_done_a = 1'b0;
   logic tx_done_f = 1'b0;
   int   uart_cnt  = 0;
   assign bus.tx_done = tx_done_a | tx_done_f;

   always @(negedge clk) begin
      tx_done_a = 1'b0;
      if (uart_cnt > 0) begin
         uart_cnt = uart_cnt - 1;
         if (uart_cnt == 0) tx_done_a = 1'b1;
      end else if (bus.trmt) begin
         uart_cnt = 5;
      end
   end

   int n_chk = 0;
   int n_pass = 0;
   int trmt_cnt = 0;
   int done_cnt = 0;
   int clr_cnt = 0;
   int rej_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   // Monitor: consumes every strobed byte and tallies the pulse outputs.
   always @(negedge clk) begin
      if (bus.trmt) begin
         trmt_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_trmt", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("tx_data", int'(bus.tx_data), int'(mon_e));
         end
      end
      if (bus.dump_done || bus.clr_cap_done) begin
         done_cnt += int'(bus.dump_done);
         clr_cnt  += int'(bus.clr_cap_done);
         chk("clr_with_done", int'(bus.clr_cap_done), int'(bus.dump_done));
      end
      if (bus.dump_rej) rej_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push_seq(input int start);
      for (int i = 0; i < ENT; i++) exp_q.push_back(8'hA0 + 8'((start + i) % ENT));
   endtask

   task automatic pulse_start();
      bus.dump_start = 1'b1;
      tick(1);
      bus.dump_start = 1'b0;
   endtask

   task automatic wait_trmt(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (trmt_cnt < target && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, int'(trmt_cnt >= target), 1);
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         tick(1);
         k++;
      end
      chk(name, int'(done_cnt >= target), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_raddr"},   int'(bus.raddr), 0);
      chk({tag, "_tx_data"}, int'(bus.tx_data), 0);
      chk({tag, "_trmt"},    int'(bus.trmt), 0);
      chk({tag, "_busy"},    int'(bus.busy), 0);
      chk({tag, "_rej"},     int'(bus.dump_rej), 0);
      chk({tag, "_done"},    int'(bus.dump_done), 0);
      chk({tag, "_clr"},     int'(bus.clr_cap_done), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      int d0;
      int r0;
      bus.capture_done = 1'b0;
      bus.waddr        = 3'd0;
      bus.dump_start   = 1'b0;
      bus.dump_abort   = 1'b0;
      rst_n            = 1'b0;
      tick(2);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick(1);

      // 1: wrapped dump starting at waddr=3
      bus.capture_done = 1'b1;
      bus.waddr        = 3'd3;
      t0 = trmt_cnt;
      push_seq(3);
      pulse_start();
      wait_done(1, 300, "t1_done_seen");
      chk("t1_byte_count", trmt_cnt - t0, 8);
      tick(1);
      chk("t1_busy_after", int'(bus.busy), 0);
      chk("t1_clr_count", clr_cnt, 1);
      chk("t1_queue_empty", exp_q.size(), 0);

      // 2: waddr=0 dump with start-to-trmt latency
      bus.waddr = 3'd0;
      t0 = trmt_cnt;
      push_seq(0);
      bus.dump_start = 1'b1;
      tick(1);
      bus.dump_start = 1'b0;
      tick(1);
      chk("t2_trmt_cycle2", int'(bus.trmt), 0);
      tick(1);
      chk("t2_trmt_cycle3", int'(bus.trmt), 1);
      wait_done(2, 300, "t2_done_seen");
      chk("t2_byte_count", trmt_cnt - t0, 8);
      tick(1);
      chk("t2_busy_after", int'(bus.busy), 0);

      // 3: start refused without a completed capture
      bus.capture_done = 1'b0;
      t0 = trmt_cnt;
      pulse_start();
      chk("t3_rej_pulse", int'(bus.dump_rej), 1);
      chk("t3_busy", int'(bus.busy), 0);
      tick(6);
      chk("t3_no_trmt", trmt_cnt - t0, 0);
      chk("t3_rej_count", rej_cnt, 1);

      // 4: abort after the third byte, then a clean re-dump
      bus.capture_done = 1'b1;
      bus.waddr        = 3'd3;
      t0 = trmt_cnt;
      push_seq(3);
      pulse_start();
      wait_trmt(t0 + 3, 100, "t4_three_bytes");
      tick(2);
      bus.dump_abort = 1'b1;
      tick(1);
      bus.dump_abort = 1'b0;
      exp_q.delete();
      chk("t4_busy_after_abort", int'(bus.busy), 0);
      d0 = done_cnt;
      tick(8);
      chk("t4_no_done", done_cnt - d0, 0);
      chk("t4_no_more_bytes", trmt_cnt - t0, 3);
      t0 = trmt_cnt;
      push_seq(3);
      pulse_start();
      wait_done(d0 + 1, 300, "t4_redump_done");
      chk("t4_redump_count", trmt_cnt - t0, 8);
      tick(1);

      // 5: reset in WAIT_TX abandons the byte in flight
      t0 = trmt_cnt;
      push_seq(3);
      pulse_start();
      wait_trmt(t0 + 1, 20, "t5_first_byte");
      tick(1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      exp_q.delete();
      check_idle_outputs("t5_rst");
      tick(12);
      chk("t5_no_trmt_after", trmt_cnt - t0, 1);
      chk("t5_busy_after", int'(bus.busy), 0);

      // 6: start held while busy, waddr moved mid-dump, abort racing tx_done
      r0 = rej_cnt;
      d0 = done_cnt;
      t0 = trmt_cnt;
      push_seq(3);
      bus.dump_start = 1'b1;
      tick(1);
      bus.waddr = 3'd5;
      tick(19);
      bus.dump_start = 1'b0;
      wait_trmt(t0 + 4, 100, "t6_four_bytes");
      tick(1);
      tx_done_f      = 1'b1;
      bus.dump_abort = 1'b1;
      tick(1);
      tx_done_f      = 1'b0;
      bus.dump_abort = 1'b0;
      exp_q.delete();
      chk("t6_busy_after_abort", int'(bus.busy), 0);
      tick(10);
      chk("t6_byte_count", trmt_cnt - t0, 4);
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_no_rej", rej_cnt - r0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
